// File: rtl/fetch_pc_gen_pkg.sv
// Shared fetch-stage definitions: opcodes, reset PC, widths and PHT init value.
package fetch_pc_gen_pkg;

  localparam int          DEF_PC_WIDTH    = 32;
  localparam int          DEF_INSTR_WIDTH = 32;
  localparam int          history_WIDTH   = 8;
  localparam logic [31:0] DEF_RESET_PC    = 32'h8000_0000;

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;

  // weak not-taken
  localparam logic [1:0]  PHT_INIT   = 2'b01;

endpackage

// File: rtl/fetch_pc_gen_bpu_pht.sv
// Gshare pattern history table: 2-bit saturating counters, combinational read,
// synchronous update; a same-cycle read of the written entry returns the old value.
module bpu_pht
  import fetch_pc_gen_pkg::*;
#(
  parameter int HIST_WIDTH = history_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst,
  input  logic [HIST_WIDTH-1:0] i_rd_idx,
  output logic [1:0]            o_rd_ctr,
  input  logic                  i_wr_en,
  input  logic [HIST_WIDTH-1:0] i_wr_idx,
  input  logic                  i_wr_taken
);

  localparam int DEPTH = 1 << HIST_WIDTH;

  logic [1:0] r_ctr [DEPTH];
  logic [1:0] w_old;

  assign o_rd_ctr = r_ctr[i_rd_idx];
  assign w_old    = r_ctr[i_wr_idx];

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_ctr[i] <= PHT_INIT;
    end else if (i_wr_en) begin
      if (i_wr_taken) begin
        if (w_old != 2'b11) r_ctr[i_wr_idx] <= w_old + 2'b01;
      end else begin
        if (w_old != 2'b00) r_ctr[i_wr_idx] <= w_old - 2'b01;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: holds PC and GHR, decodes branch/JAL immediates and
// selects the predicted next PC from a gshare predictor.
module fetch_pc_gen
  import fetch_pc_gen_pkg::*;
#(
  parameter int                   PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                   INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int                   HIST_WIDTH  = history_WIDTH,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = PC_WIDTH'(DEF_RESET_PC)
) (
  input  logic                   clk_i,
  input  logic                   rst,
  input  logic                   F_stall_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic                   E_redirect_i,
  input  logic [PC_WIDTH-1:0]    E_redirect_PC_i,
  input  logic                   E_train_vaild_i,
  input  logic                   E_train_taken_i,
  input  logic [PC_WIDTH-1:0]    E_train_PC_i,
  input  logic [HIST_WIDTH-1:0]  E_train_history_i,
  output logic [PC_WIDTH-1:0]    F_PC_o,
  output logic [PC_WIDTH-1:0]    F_nPC_o,
  output logic                   F_commit_o,
  output logic                   F_train_predict_o,
  output logic                   F_train_vaild_o,
  output logic [HIST_WIDTH-1:0]  F_train_history_o
);

  logic [PC_WIDTH-1:0]   r_pc;
  logic [HIST_WIDTH-1:0] r_ghr;
  logic                  r_commit;

  logic                  w_is_br;
  logic                  w_is_jal;
  logic signed [12:0]    w_imm_b;
  logic signed [20:0]    w_imm_j;
  logic [PC_WIDTH-1:0]   w_pc_plus4;
  logic [PC_WIDTH-1:0]   w_tgt_b;
  logic [PC_WIDTH-1:0]   w_tgt_j;
  logic [HIST_WIDTH-1:0] w_rd_idx;
  logic [HIST_WIDTH-1:0] w_wr_idx;
  logic [1:0]            w_ctr;
  logic                  w_unused_train_pc;

  assign w_is_br  = (instr_i[6:0] == OPC_BRANCH);
  assign w_is_jal = (instr_i[6:0] == OPC_JAL);

  assign w_imm_b  = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign w_imm_j  = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
  assign w_tgt_b    = r_pc + PC_WIDTH'(w_imm_b);
  assign w_tgt_j    = r_pc + PC_WIDTH'(w_imm_j);

  assign w_rd_idx = r_pc[HIST_WIDTH+1:2] ^ r_ghr;
  assign w_wr_idx = E_train_PC_i[HIST_WIDTH+1:2] ^ E_train_history_i;
  // only the index bits of the trained PC select a counter
  assign w_unused_train_pc = ^{E_train_PC_i[PC_WIDTH-1:HIST_WIDTH+2], E_train_PC_i[1:0]};

  bpu_pht #(.HIST_WIDTH(HIST_WIDTH)) u_pht (
    .clk_i      (clk_i),
    .rst        (rst),
    .i_rd_idx   (w_rd_idx),
    .o_rd_ctr   (w_ctr),
    .i_wr_en    (E_train_vaild_i),
    .i_wr_idx   (w_wr_idx),
    .i_wr_taken (E_train_taken_i)
  );

  always_comb begin
    F_nPC_o           = w_pc_plus4;
    F_train_predict_o = 1'b0;
    F_train_vaild_o   = 1'b0;
    if (w_is_br) begin
      F_train_vaild_o   = 1'b1;
      F_train_predict_o = w_ctr[1];
      if (w_ctr[1]) F_nPC_o = w_tgt_b;
    end else if (w_is_jal) begin
      F_train_predict_o = 1'b1;
      F_nPC_o           = w_tgt_j;
    end
  end

  assign F_PC_o            = r_pc;
  assign F_train_history_o = r_ghr;
  // a fetch that execute is redirecting away from is on the wrong path
  assign F_commit_o        = r_commit & ~E_redirect_i;

  always_ff @(posedge clk_i) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_ghr    <= '0;
      r_commit <= 1'b0;
    end else begin
      r_commit <= 1'b1;
      if (E_redirect_i) begin
        r_pc <= E_redirect_PC_i;
        if (E_train_vaild_i) r_ghr <= {E_train_history_i[HIST_WIDTH-2:0], E_train_taken_i};
      end else if (!F_stall_i) begin
        r_pc <= F_nPC_o;
        if (w_is_br) r_ghr <= {r_ghr[HIST_WIDTH-2:0], F_train_predict_o};
      end
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Scoreboard bench for fetch_pc_gen: directed scenarios followed by random traffic,
// each cycle checked against a behavioural gshare model.
module tb_fetch_pc_gen;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        F_stall_i;
  logic [31:0] instr_i;
  logic        E_redirect_i;
  logic [31:0] E_redirect_PC_i;
  logic        E_train_vaild_i;
  logic        E_train_taken_i;
  logic [31:0] E_train_PC_i;
  logic [7:0]  E_train_history_i;
  logic [31:0] F_PC_o;
  logic [31:0] F_nPC_o;
  logic        F_commit_o;
  logic        F_train_predict_o;
  logic        F_train_vaild_o;
  logic [7:0]  F_train_history_o;

  fetch_pc_gen dut (
    .clk_i             (clk_i),
    .rst               (rst),
    .F_stall_i         (F_stall_i),
    .instr_i           (instr_i),
    .E_redirect_i      (E_redirect_i),
    .E_redirect_PC_i   (E_redirect_PC_i),
    .E_train_vaild_i   (E_train_vaild_i),
    .E_train_taken_i   (E_train_taken_i),
    .E_train_PC_i      (E_train_PC_i),
    .E_train_history_i (E_train_history_i),
    .F_PC_o            (F_PC_o),
    .F_nPC_o           (F_nPC_o),
    .F_commit_o        (F_commit_o),
    .F_train_predict_o (F_train_predict_o),
    .F_train_vaild_o   (F_train_vaild_o),
    .F_train_history_o (F_train_history_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        commit;
    logic        predict;
    logic        vaild;
    logic [7:0]  hist;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_push = 0;
  int   n_pop  = 0;

  // behavioural model state
  logic [31:0] m_pc;
  int          m_ghr;
  int          m_pht [256];
  bit          m_commit;
  bit          m_known = 0;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] BEQ_M8 = 32'hFE00_0CE3;
  localparam logic [31:0] JAL_P100 = 32'h1000_006F;

  function automatic logic [31:0] imem(input logic [31:0] pc);
    if (pc == 32'h8000_0010 || pc == 32'h8000_0400) return BEQ_M8;
    if (pc == 32'h8000_0020) return JAL_P100;
    return ADDI;
  endfunction

  task automatic drive(input bit r, input bit st, input logic [31:0] ins,
                       input bit rd, input logic [31:0] rpc,
                       input bit tv, input bit tt, input logic [31:0] tpc,
                       input logic [7:0] th);
    exp_t e;
    int   bimm, jimm, idx, tidx;
    bit   isbr, isjal, pred;
    rst = r; F_stall_i = st; instr_i = ins; E_redirect_i = rd; E_redirect_PC_i = rpc;
    E_train_vaild_i = tv; E_train_taken_i = tt; E_train_PC_i = tpc; E_train_history_i = th;

    isbr  = (ins[6:0] == 7'b1100011);
    isjal = (ins[6:0] == 7'b1101111);
    bimm  = (int'(ins[31]) << 12) + (int'(ins[7]) << 11) + (int'(ins[30:25]) << 5) + (int'(ins[11:8]) << 1);
    if (bimm >= 4096) bimm -= 8192;
    jimm  = (int'(ins[31]) << 20) + (int'(ins[19:12]) << 12) + (int'(ins[20]) << 11) + (int'(ins[30:21]) << 1);
    if (jimm >= (1 << 20)) jimm -= (1 << 21);
    idx   = (int'(m_pc[31:2]) % 256) ^ m_ghr;
    pred  = isjal ? 1'b1 : (isbr && m_pht[idx] >= 2);

    e.pc      = m_pc;
    e.hist    = m_ghr[7:0];
    e.commit  = m_commit && !rd;
    e.vaild   = isbr;
    e.predict = pred;
    if (isjal)             e.npc = m_pc + 32'(jimm);
    else if (isbr && pred) e.npc = m_pc + 32'(bimm);
    else                   e.npc = m_pc + 32'd4;
    if (m_known) begin
      sb.push_back(e);
      n_push++;
    end

    if (!r) begin
      m_pc = 32'h8000_0000; m_ghr = 0; m_commit = 0; m_known = 1;
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
    end else begin
      m_commit = 1;
      if (tv) begin
        tidx = (int'(tpc[31:2]) % 256) ^ int'(th);
        if (tt) m_pht[tidx] = (m_pht[tidx] == 3) ? 3 : m_pht[tidx] + 1;
        else    m_pht[tidx] = (m_pht[tidx] == 0) ? 0 : m_pht[tidx] - 1;
      end
      if (rd) begin
        m_pc = rpc;
        if (tv) m_ghr = ((int'(th) * 2) + int'(tt)) % 256;
      end else if (!st) begin
        m_pc = e.npc;
        if (isbr) m_ghr = ((m_ghr * 2) + int'(pred)) % 256;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch(input int n);
    for (int i = 0; i < n; i++) drive(1, 0, imem(m_pc), 0, 0, 0, 0, 0, 0);
  endtask

  // monitor: the DUT presents a fetch every cycle; compare mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_pop++;
        n_cmp++;
        if (F_PC_o !== e.pc || F_nPC_o !== e.npc || F_commit_o !== e.commit ||
            F_train_predict_o !== e.predict || F_train_vaild_o !== e.vaild ||
            F_train_history_o !== e.hist) begin
          n_fail++;
          $display("FAIL fetch#%0d got pc=%h npc=%h commit=%b pred=%b vaild=%b hist=%h exp pc=%h npc=%h commit=%b pred=%b vaild=%b hist=%h",
                   n_pop, F_PC_o, F_nPC_o, F_commit_o, F_train_predict_o, F_train_vaild_o,
                   F_train_history_o, e.pc, e.npc, e.commit, e.predict, e.vaild, e.hist);
        end
      end
    end
  end

  initial begin
    logic [31:0] rv;
    int          kind;
    int          waited;
    m_pc = '0; m_ghr = 0; m_commit = 0;
    for (int i = 0; i < 256; i++) m_pht[i] = 0;
    #2;
    // reset for two cycles
    drive(0, 0, ADDI, 0, 0, 0, 0, 0, 0);
    drive(0, 0, ADDI, 0, 0, 0, 0, 0, 0);
    // sequential fetch through cold BEQ at 0x10 and JAL at 0x20
    fetch(12);
    // three taken trainings for the BEQ with history 0
    for (int i = 0; i < 3; i++) drive(1, 0, imem(m_pc), 0, 0, 1, 1, 32'h8000_0010, 8'h00);
    // re-fetch the now strongly-taken BEQ
    drive(1, 0, imem(m_pc), 1, 32'h8000_0010, 0, 0, 0, 0);
    fetch(5);
    // redirect overriding a stall, with history repair
    drive(1, 1, imem(m_pc), 1, 32'h8000_0400, 1, 1, 32'h8000_0010, 8'h5A);
    // stall hold while training the counter the held BEQ reads
    for (int i = 0; i < 3; i++) drive(1, 1, imem(m_pc), 0, 0, 1, 1, 32'h8000_0400, 8'hB5);
    fetch(3);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rv   = $urandom;
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: rv[6:0] = 7'b1100011;
        2:    rv[6:0] = 7'b1101111;
        default: rv[6:0] = 7'b0010011;
      endcase
      drive($urandom_range(0, 299) != 0,
            $urandom_range(0, 4) == 0,
            rv,
            $urandom_range(0, 9) == 0,
            {$urandom_range(0, 1) ? 8'h80 : 8'hFF, 24'($urandom)} & 32'hFFFF_FFFC,
            $urandom_range(0, 2) == 0,
            1'($urandom),
            $urandom_range(0, 1) ? m_pc : $urandom,
            $urandom_range(0, 1) ? m_ghr[7:0] : 8'($urandom));
    end

    waited = 0;
    while (sb.size() > 0 && waited < 10) begin
      @(posedge clk_i);
      waited++;
    end
    n_cmp++;
    if (sb.size() != 0 || n_pop != n_push) begin
      n_fail++;
      $display("FAIL drain popped=%0d pushed=%0d left=%0d", n_pop, n_push, sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
